// File: rtl/fibonacci_stream_gen.sv
// Streams a Fibonacci-style sequence from two seeds over a valid/ready handshake.
// state | meaning:  IDLE | waiting for i_start;  RUN | presenting term a;  DONE | one-cycle completion pulse
module fibonacci_stream_gen #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_WRAP = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_seed0,
  input  logic [WIDTH-1:0] i_seed1,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_term,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_wrap,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_trunc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic             a_wrap, b_wrap;
  logic [CNT_W-1:0] rem, idx;
  logic             trunc;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             stop_wrap;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign stop_wrap = (STOP_ON_WRAP != 0) && b_wrap;
  assign last      = (rem == CNT_W'(1)) || stop_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      a_wrap <= 1'b0;
      b_wrap <= 1'b0;
      rem    <= '0;
      idx    <= '0;
      trunc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a      <= i_seed0;
            b      <= i_seed1;
            a_wrap <= 1'b0;
            b_wrap <= 1'b0;
            rem    <= i_count;
            idx    <= '0;
            trunc  <= 1'b0;
            state  <= (i_count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (i_flush) begin
            state <= IDLE;
          end else if (i_ready) begin
            if (last) begin
              // The final term stays on o_term/o_idx so they hold in IDLE.
              state <= DONE;
              if (rem != CNT_W'(1)) trunc <= 1'b1;
            end else begin
              a      <= b;
              a_wrap <= b_wrap;
              b      <= sum[WIDTH-1:0];
              b_wrap <= a_wrap | b_wrap | sum[WIDTH];
              idx    <= idx + CNT_W'(1);
              rem    <= rem - CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_term  = a;
  assign o_idx   = idx;
  assign o_wrap  = a_wrap;
  assign o_valid = (state == RUN);
  assign o_last  = (state == RUN) && last;
  assign o_done  = (state == DONE);
  assign o_busy  = (state != IDLE);
  assign o_trunc = trunc;

endmodule

// File: tb/tb_fibonacci_stream_gen.sv
// Two 8-bit instances (wrap tolerated / stop before wrap) share stimulus and are
// checked against an arithmetic model of the unbounded sequence.
module tb_fibonacci_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, ready;
  logic [7:0]  seed0, seed1;
  logic [15:0] count;

  logic [7:0]  term  [2];
  logic [15:0] idx   [2];
  logic        valid [2];
  logic        last  [2];
  logic        wrap  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        trunc [2];

  int n_chk  = 0;
  int n_pass = 0;

  int  exp_t  [2][32];
  bit  exp_w  [2][32];
  int  exp_n  [2];
  bit  exp_tr [2];

  always #5 clk = ~clk;

  fibonacci_stream_gen #(.WIDTH(8), .CNT_W(16), .STOP_ON_WRAP(0)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_seed0(seed0), .i_seed1(seed1), .i_count(count), .i_ready(ready),
    .o_term(term[0]), .o_idx(idx[0]), .o_valid(valid[0]), .o_last(last[0]),
    .o_wrap(wrap[0]), .o_busy(busy[0]), .o_done(done[0]), .o_trunc(trunc[0]));

  fibonacci_stream_gen #(.WIDTH(8), .CNT_W(16), .STOP_ON_WRAP(1)) dut_stop (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_seed0(seed0), .i_seed1(seed1), .i_count(count), .i_ready(ready),
    .o_term(term[1]), .o_idx(idx[1]), .o_valid(valid[1]), .o_last(last[1]),
    .o_wrap(wrap[1]), .o_busy(busy[1]), .o_done(done[1]), .o_trunc(trunc[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: exact sequence values in wide arithmetic; a term "wraps" when its
  // true value does not fit in 8 bits.
  task automatic build(input int s0, input int s1, input int cnt);
    for (int d = 0; d < 2; d++) begin
      longint x = s0, y = s1, t;
      exp_n[d]  = 0;
      exp_tr[d] = 1'b0;
      for (int i = 0; i < cnt; i++) begin
        if (d == 1 && x > 255) begin
          exp_tr[d] = 1'b1;
          break;
        end
        exp_t[d][i] = int'(x % 256);
        exp_w[d][i] = (x > 255);
        exp_n[d]++;
        t = x + y;
        x = y;
        y = t;
      end
    end
  endtask

  task automatic run_seq(input int s0, input int s1, input int cnt,
                         input bit rnd_ready, input int stall_idx);
    int  k [2];
    bit  seen [2];
    int  stalls = 0;
    bit  first  = 1'b1;
    build(s0, s1, cnt);
    seed0 = 8'(s0);
    seed1 = 8'(s1);
    count = 16'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seed0 = 8'($urandom);
    seed1 = 8'($urandom);
    count = 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      k[d] = 0;
      seen[d] = 1'b0;
    end
    for (int cyc = 0; cyc < 300 && !(seen[0] && seen[1]); cyc++) begin
      if (stall_idx >= 0 && valid[0] && int'(idx[0]) == stall_idx && stalls < 3) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (first) begin
          chk("first_valid", valid[d], exp_n[d] != 0);
          chk("first_done", done[d], exp_n[d] == 0);
        end
        if (valid[d]) begin
          if (k[d] < exp_n[d]) begin
            chk("term", term[d], exp_t[d][k[d]]);
            chk("idx", idx[d], k[d]);
            chk("wrap", wrap[d], exp_w[d][k[d]]);
            chk("last", last[d], k[d] == exp_n[d] - 1);
            if (ready) k[d]++;
          end else begin
            chk("extra_valid", valid[d], 1'b0);
          end
        end
        if (done[d]) begin
          if (seen[d]) chk("done_twice", done[d], 1'b0);
          chk("done_count", k[d], exp_n[d]);
          chk("done_valid", valid[d], 1'b0);
          chk("trunc", trunc[d], exp_tr[d]);
          seen[d] = 1'b1;
        end
      end
      first = 1'b0;
      @(posedge clk);
      #1;
    end
    if (stall_idx >= 0) chk("stall_cycles", stalls, 3);
    for (int d = 0; d < 2; d++) chk("timeout", seen[d], 1'b1);
    ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("idle_busy", busy[d], 1'b0);
      chk("idle_done", done[d], 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    seed0 = '0;
    seed1 = '0;
    count = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_term", term[d], 0);
      chk("rst_valid", valid[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_trunc", trunc[d], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("no_term_before_start", valid[0], 0);
    @(posedge clk);
    #1;

    run_seq(0, 1, 5, 1'b0, -1);
    run_seq(0, 1, 5, 1'b0, 3);
    run_seq(89, 144, 4, 1'b0, -1);
    run_seq(89, 144, 6, 1'b1, -1);
    run_seq(7, 9, 0, 1'b0, -1);
    run_seq(1, 1, 1, 1'b0, -1);

    // Flush mid-run drops valid next cycle with no completion pulse.
    seed0 = 8'd3; seed1 = 8'd4; count = 16'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("flush_valid", valid[d], 0);
      chk("flush_done", done[d], 0);
      chk("flush_busy", busy[d], 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_no_late_done", done[0], 0);

    // Asynchronous reset between edges clears outputs without a clock.
    @(posedge clk); #1;
    seed0 = 8'd5; seed1 = 8'd8; count = 16'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_term", term[0], 0);
    chk("arst_idx", idx[0], 0);
    chk("arst_valid", valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_last", last[1], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq(2, 3, 8, 1'b1, -1);

    for (int r = 0; r < 20; r++)
      run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 20)), 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
